reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the successor to the single-write, dual-read register file. It adds configurable depth, width and read/write port count, same-cycle write-to-read bypass, and per-register pending tracking for the pipeline hazard unit. It sits between decode (read and scoreboard set) and writeback (write and scoreboard clear).

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 always reads zero, ignores writes, never busy
BYPASS, 1, 1 = read ports return same-cycle write data
AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses, port k at [k*AW +: AW]
wr_data  in  NUM_WR*DATA_WIDTH  write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
rd_addr  in  NUM_RD*AW  read addresses, port j at [j*AW +: AW]
rd_data  out  NUM_RD*DATA_WIDTH  combinational read data per port
rd_busy  out  NUM_RD  busy bit of the register addressed by each read port
sb_set_en  in  1  mark sb_set_addr pending (instruction issued with destination)
sb_set_addr  in  AW  destination register to mark pending
sb_flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NUM_REGS  current busy bit of every register

Behaviour:
- Reset: rst high asynchronously clears all registers and all busy bits to 0. While rst is high, rd_data = 0, rd_busy = 0, busy_vec = 0. Writes and sets are ignored. Deassertion is released on the next clk edge.
- Write: on rising clk, for each k with wr_en[k]=1, reg[wr_addr[k]] <= wr_data[k].
- Write conflict: if two write ports target the same address in one cycle, the higher port index wins.
- Register 0 (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - rd_data for address 0 is always 0, including under bypass.
  - busy bit 0 is never set.
- Read: rd_data[j] = reg[rd_addr[j]] combinationally, with zero cycles of latency.
- Bypass (BYPASS=1): if any enabled write port targets rd_addr[j] in the current cycle, rd_data[j] returns that port's wr_data. When several ports match, the highest index wins, consistent with the write rule. With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, next-state per register r:
  - sb_flush=1: busy[r] <= 0. Flush overrides set and clear.
  - Otherwise, sb_set_en=1 with sb_set_addr=r: busy[r] <= 1. Set wins over a same-cycle write clear to the same register, because a new producer has issued.
  - Otherwise, any wr_en[k]=1 with wr_addr[k]=r: busy[r] <= 0.
  - Otherwise, busy[r] holds.
- busy_vec and rd_busy reflect registered state only. rd_busy[j] = busy[rd_addr[j]]. A same-cycle set or clear is visible next cycle, with no bypass on busy.
- Out-of-range behaviour is not applicable: addresses are exactly AW wide and all codes are valid.
- Width rules: no arithmetic. Data is stored and returned bit-exact.
- Reset mid-operation: state is cleared immediately, and in-flight writes in that cycle are lost.

Test Plan:
1. Reset: assert rst mid-cycle after loading reg5=0xDEADBEEF -> rd_data for addr 5 reads 0x00000000 immediately, busy_vec=0. After release, a write of 0x1234 to reg5 reads back 0x1234 next cycle.
2. Register 0: wr_en[0]=1, addr 0, data 0xFFFFFFFF; sb_set_en with addr 0 -> rd_data(addr 0)=0 in the same and next cycle, busy_vec[0]=0.
3. Bypass and dual-write conflict (NUM_WR=2): port0 writes 0xAAAA0000 and port1 writes 0x0000BBBB to reg7, while port0 reads reg7 in the same cycle -> rd_data=0x0000BBBB in the same cycle, reg7=0x0000BBBB afterwards. Repeat with BYPASS=0 -> old value in the same cycle, 0x0000BBBB next cycle.
4. Scoreboard lifecycle: set reg3 in cycle n -> busy_vec[3]=1 and rd_busy=1 from n+1. Write reg3 in cycle n+4 -> busy_vec[3]=0 from n+5.
5. Set/clear collision and flush: same cycle sb_set reg9 and write reg9 -> busy[9]=1 next cycle. Then set reg10, and assert sb_flush together with sb_set on reg11 -> busy_vec all 0 next cycle.
6. Parameter sweep: NUM_REGS=16, DATA_WIDTH=64, NUM_RD=4. Write distinct 64-bit patterns to all 16 registers, then read 4 at a time -> every value exact, AW=4.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bundle of write, read and scoreboard signals for reg_file_mp.
// Parameters must match the register file instance that uses it.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*AW-1:0]         wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_RD*AW-1:0]         rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         sb_set_en;
  logic [AW-1:0]                sb_set_addr;
  logic                         sb_flush;
  logic [NUM_REGS-1:0]          busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr,
    output sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr,
    input  sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write bypass
// and a per-register busy scoreboard for the hazard unit.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]            rd_busy_c;

  // Later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (bus.wr_en[k]) begin
        regs_d[bus.wr_addr[k*AW +: AW]] =
          bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
    end
  end

  // Priority: flush, then set, then writeback clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] && bus.wr_addr[k*AW +: AW] == AW'(r)) begin
          busy_d[r] = 1'b0;
        end
      end
      if (bus.sb_set_en && bus.sb_set_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end
    end
    if (bus.sb_flush) begin
      busy_d = '0;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      logic [AW-1:0]         a;
      logic [DATA_WIDTH-1:0] d;
      a = bus.rd_addr[j*AW +: AW];
      d = regs_q[a];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.wr_en[k] && bus.wr_addr[k*AW +: AW] == a) begin
            d = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      if (ZERO_REG && a == '0) begin
        d = '0;
      end
      // Bypass must not leak write data while reset is held.
      if (rst) begin
        d = '0;
      end
      rd_data_c[j*DATA_WIDTH +: DATA_WIDTH] = d;
      rd_busy_c[j] = rst ? 1'b0 : busy_q[a];
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_vec = rst ? '0 : busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: reset, r0, bypass,
// write conflicts, scoreboard and a wide/deep variant.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32),
                   .NUM_RD(2), .NUM_WR(2)) ia ();
  reg_file_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32),
                   .NUM_RD(2), .NUM_WR(2)) ib ();
  reg_file_mp_if #(.DATA_WIDTH(64), .NUM_REGS(16),
                   .NUM_RD(4), .NUM_WR(1)) ic ();

  reg_file_mp #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(2),
    .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  reg_file_mp #(
    .DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD(2),
    .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  reg_file_mp #(
    .DATA_WIDTH(64), .NUM_REGS(16), .NUM_RD(4),
    .NUM_WR(1), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int r);
    return 64'h0123_4567_89AB_CDEF ^ (64'h1111_1111_1111_1111 * r);
  endfunction

  initial begin
    ia.wr_en = '0; ia.wr_addr = '0; ia.wr_data = '0;
    ia.rd_addr = '0; ia.sb_set_en = 0; ia.sb_set_addr = '0;
    ia.sb_flush = 0;
    ib.wr_en = '0; ib.wr_addr = '0; ib.wr_data = '0;
    ib.rd_addr = '0; ib.sb_set_en = 0; ib.sb_set_addr = '0;
    ib.sb_flush = 0;
    ic.wr_en = '0; ic.wr_addr = '0; ic.wr_data = '0;
    ic.rd_addr = '0; ic.sb_set_en = 0; ic.sb_set_addr = '0;
    ic.sb_flush = 0;

    step; step;
    ia.rd_addr = {5'd0, 5'd5};
    #1;
    check("rst_rd5", ia.rd_data[31:0], 64'h0);
    check("rst_busy", ia.busy_vec, 64'h0);
    rst = 1'b0;

    // Load reg5, then reset mid-cycle
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd5};
    ia.wr_data = {32'h0, 32'hDEADBEEF};
    ia.sb_set_en = 1; ia.sb_set_addr = 5'd6;
    step;
    ia.wr_en = 2'b00; ia.sb_set_en = 0;
    check("ld_rd5", ia.rd_data[31:0], 64'hDEADBEEF);
    check("ld_busy6", ia.busy_vec, 64'h40);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd5", ia.rd_data[31:0], 64'h0);
    check("mid_rst_busy", ia.busy_vec, 64'h0);
    #1 rst = 1'b0;
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd5};
    ia.wr_data = {32'h0, 32'h00001234};
    step;
    ia.wr_en = 2'b00;
    check("post_rst_rd5", ia.rd_data[31:0], 64'h1234);

    // Register 0 ignores writes and sets
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd0};
    ia.wr_data = {32'h0, 32'hFFFFFFFF};
    ia.sb_set_en = 1; ia.sb_set_addr = 5'd0;
    ia.rd_addr = {5'd5, 5'd0};
    #1;
    check("r0_same", ia.rd_data[31:0], 64'h0);
    step;
    ia.wr_en = 2'b00; ia.sb_set_en = 0;
    check("r0_next", ia.rd_data[31:0], 64'h0);
    check("r0_busy", ia.busy_vec, 64'h0);
    check("r5_port1", ia.rd_data[63:32], 64'h1234);

    // Preload reg7 in both bypass variants
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd7};
    ia.wr_data = {32'h0, 32'h11111111};
    ib.wr_en = 2'b01; ib.wr_addr = {5'd0, 5'd7};
    ib.wr_data = {32'h0, 32'h11111111};
    step;
    ia.wr_en = 2'b00; ib.wr_en = 2'b00;

    // Dual-write conflict on reg7
    ia.wr_en = 2'b11; ia.wr_addr = {5'd7, 5'd7};
    ia.wr_data = {32'h0000BBBB, 32'hAAAA0000};
    ia.rd_addr = {5'd5, 5'd7};
    ib.wr_en = 2'b11; ib.wr_addr = {5'd7, 5'd7};
    ib.wr_data = {32'h0000BBBB, 32'hAAAA0000};
    ib.rd_addr = {5'd0, 5'd7};
    #1;
    check("byp_same", ia.rd_data[31:0], 64'h0000BBBB);
    check("nobyp_same", ib.rd_data[31:0], 64'h11111111);
    step;
    ia.wr_en = 2'b00; ib.wr_en = 2'b00;
    check("byp_next", ia.rd_data[31:0], 64'h0000BBBB);
    check("nobyp_next", ib.rd_data[31:0], 64'h0000BBBB);

    // Port 0 alone bypasses to read port 1
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd5};
    ia.wr_data = {32'h0, 32'hCAFEF00D};
    #1;
    check("byp_p0_rd1", ia.rd_data[63:32], 64'hCAFEF00D);
    step;
    ia.wr_en = 2'b00;

    // Scoreboard lifecycle on reg3
    ia.sb_set_en = 1; ia.sb_set_addr = 5'd3;
    ia.rd_addr = {5'd3, 5'd0};
    #1;
    check("sb_no_byp", ia.busy_vec, 64'h0);
    step;
    ia.sb_set_en = 0;
    check("sb_set3", ia.busy_vec, 64'h8);
    check("sb_rdbusy", ia.rd_busy, 64'h2);
    step; step; step;
    check("sb_hold3", ia.busy_vec, 64'h8);
    ia.wr_en = 2'b10; ia.wr_addr = {5'd3, 5'd0};
    ia.wr_data = {32'h33, 32'h0};
    #1;
    check("sb_clr_same", ia.busy_vec, 64'h8);
    step;
    ia.wr_en = 2'b00;
    check("sb_clr3", ia.busy_vec, 64'h0);
    check("sb_rdbusy0", ia.rd_busy, 64'h0);

    // Set beats same-cycle clear
    ia.sb_set_en = 1; ia.sb_set_addr = 5'd9;
    ia.wr_en = 2'b01; ia.wr_addr = {5'd0, 5'd9};
    ia.wr_data = {32'h0, 32'h99};
    step;
    ia.wr_en = 2'b00;
    check("sb_set_wins", ia.busy_vec, 64'h200);
    ia.sb_set_addr = 5'd10;
    step;
    check("sb_set10", ia.busy_vec, 64'h600);
    ia.sb_set_addr = 5'd11; ia.sb_flush = 1;
    step;
    ia.sb_set_en = 0; ia.sb_flush = 0;
    check("sb_flush", ia.busy_vec, 64'h0);

    // Wide/deep variant: 16 x 64, four read ports
    for (int r = 0; r < 16; r++) begin
      ic.wr_en = 1'b1;
      ic.wr_addr = 4'(r);
      ic.wr_data = pat(r);
      step;
    end
    ic.wr_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ic.rd_addr = {4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)};
      #1;
      for (int j = 0; j < 4; j++) begin
        logic [63:0] e;
        e = (4*g+j == 0) ? 64'h0 : pat(4*g+j);
        check($sformatf("wide_r%0d", 4*g+j),
              ic.rd_data[j*64 +: 64], e);
      end
    end
    check("wide_busy", ic.busy_vec, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
